// File: rtl/nand_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nand_seq_pkg : command codes, state and step encodings shared by the  |
// |                NAND read sequencer and its command issuer.           |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
package nand_seq_pkg;

    // Command codes, aligned with the nand_master command defines
    localparam logic [5:0] c_CMD_M_RESET           = 6'h01;
    localparam logic [5:0] c_CMD_MI_CHIP_ENABLE    = 6'h0E;
    localparam logic [5:0] c_CMD_M_NAND_RESET      = 6'h04;
    localparam logic [5:0] c_CMD_M_NAND_READ_ID    = 6'h06;
    localparam logic [5:0] c_CMD_MI_GET_ID_BYTE    = 6'h13;
    localparam logic [5:0] c_CMD_MI_GET_STATUS     = 6'h0D;
    localparam logic [5:0] c_CMD_MI_RESET_INDEX    = 6'h12;
    localparam logic [5:0] c_CMD_M_NAND_READ       = 6'h09;
    localparam logic [5:0] c_CMD_MI_GET_PAGE_BYTE  = 6'h15;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_GUARD     = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_CAPTURE   = 3'd4,
        ST_STREAM    = 3'd5,
        ST_FINISH    = 3'd6
    } seq_state_t;

    typedef enum logic [3:0] {
        STEP_RESET      = 4'd0,
        STEP_CHIP_EN    = 4'd1,
        STEP_NAND_RESET = 4'd2,
        STEP_READ_ID    = 4'd3,
        STEP_GET_ID     = 4'd4,
        STEP_STATUS     = 4'd5,
        STEP_RST_IDX0   = 4'd6,
        STEP_READ       = 4'd7,
        STEP_RST_IDX1   = 4'd8,
        STEP_PAGE       = 4'd9
    } seq_step_t;

    function automatic logic [5:0] step_cmd(input seq_step_t step);
        logic [5:0] cmd;
        cmd = c_CMD_M_RESET;
        case (step)
            STEP_RESET:      cmd = c_CMD_M_RESET;
            STEP_CHIP_EN:    cmd = c_CMD_MI_CHIP_ENABLE;
            STEP_NAND_RESET: cmd = c_CMD_M_NAND_RESET;
            STEP_READ_ID:    cmd = c_CMD_M_NAND_READ_ID;
            STEP_GET_ID:     cmd = c_CMD_MI_GET_ID_BYTE;
            STEP_STATUS:     cmd = c_CMD_MI_GET_STATUS;
            STEP_RST_IDX0:   cmd = c_CMD_MI_RESET_INDEX;
            STEP_READ:       cmd = c_CMD_M_NAND_READ;
            STEP_RST_IDX1:   cmd = c_CMD_MI_RESET_INDEX;
            STEP_PAGE:       cmd = c_CMD_MI_GET_PAGE_BYTE;
            default:         cmd = c_CMD_M_RESET;
        endcase
        return cmd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nand_cmd_issuer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nand_cmd_issuer : launches one nand_master command, waits out the    |
// |                   guard time, then watches busy with a timeout.      |
// | Revision        : 1.0                                                |
// +----------------------------------------------------------------------+
module nand_cmd_issuer
    import nand_seq_pkg::*;
#(
    parameter int GUARD_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       i_go,
    input  logic [5:0] i_cmd,
    input  logic [7:0] i_data,
    input  logic       i_nm_busy,
    output logic [5:0] o_nm_cmd,
    output logic       o_nm_activate,
    output logic [7:0] o_nm_data_in,
    output logic       o_cmd_done,
    output logic       o_cmd_timeout
);

    localparam int c_CNT_MAX = (TIMEOUT_CYCLES > GUARD_CYCLES) ? TIMEOUT_CYCLES : GUARD_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    seq_state_t         r_state;
    seq_state_t         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [5:0]         r_cmd;
    logic [7:0]         r_data;
    logic               w_launch;

    // The launch cycle is the ISSUE cycle: the command is presented directly
    // and then held in r_cmd/r_data until the next launch.
    assign w_launch      = i_go && (r_state == ST_IDLE);
    assign o_nm_activate = w_launch;
    assign o_nm_cmd      = w_launch ? i_cmd  : r_cmd;
    assign o_nm_data_in  = w_launch ? i_data : r_data;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_cmd   <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_launch) begin
                r_cmd  <= i_cmd;
                r_data <= i_data;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        o_cmd_done    = 1'b0;
        o_cmd_timeout = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_launch) begin
                    w_state_nxt = ST_GUARD;
                    w_cnt_nxt   = '0;
                end
            end
            ST_GUARD: begin
                if (r_cnt == c_CNT_W'(GUARD_CYCLES - 1)) begin
                    w_state_nxt = ST_WAIT_BUSY;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            ST_WAIT_BUSY: begin
                if (!i_nm_busy) begin
                    o_cmd_done  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    o_cmd_timeout = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/nand_read_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nand_read_sequencer : drives nand_master through bring-up, ID/status |
// |                       capture and a streamed page read.              |
// | Revision            : 1.0                                            |
// +----------------------------------------------------------------------+
module nand_read_sequencer
    import nand_seq_pkg::*;
#(
    parameter int PAGE_BYTES     = 528,
    parameter int ID_BYTES       = 5,
    parameter int GUARD_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        start,
    input  logic [7:0]  ce_sel,
    output logic [5:0]  nm_cmd,
    output logic        nm_activate,
    output logic [7:0]  nm_data_in,
    input  logic        nm_busy,
    input  logic [7:0]  nm_data_out,
    output logic [63:0] id_bytes,
    output logic [7:0]  status,
    output logic [7:0]  pg_data,
    output logic        pg_valid,
    input  logic        pg_ready,
    output logic        pg_last,
    output logic        seq_busy,
    output logic        done,
    output logic        error
);

    seq_state_t  r_state;
    seq_state_t  w_state_nxt;
    seq_step_t   r_step;
    logic [15:0] r_pg_idx;
    logic [2:0]  r_id_idx;
    logic [7:0]  r_ce;
    logic [63:0] r_id_bytes;
    logic [7:0]  r_status;
    logic [7:0]  r_pg_data;
    logic        r_error;

    logic        w_go;
    logic [5:0]  w_cmd;
    logic [7:0]  w_data;
    logic        w_cmd_done;
    logic        w_cmd_timeout;
    logic        w_pg_last;
    logic        w_id_last;

    assign w_go      = (r_state == ST_ISSUE);
    assign w_cmd     = step_cmd(r_step);
    assign w_data    = (r_step == STEP_CHIP_EN) ? r_ce : 8'h00;
    assign w_pg_last = (r_pg_idx == 16'(PAGE_BYTES - 1));
    assign w_id_last = (r_id_idx == 3'(ID_BYTES - 1));

    nand_cmd_issuer #(
        .GUARD_CYCLES   (GUARD_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_issuer (
        .clk           (clk),
        .nreset        (nreset),
        .i_go          (w_go),
        .i_cmd         (w_cmd),
        .i_data        (w_data),
        .i_nm_busy     (nm_busy),
        .o_nm_cmd      (nm_cmd),
        .o_nm_activate (nm_activate),
        .o_nm_data_in  (nm_data_in),
        .o_cmd_done    (w_cmd_done),
        .o_cmd_timeout (w_cmd_timeout)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ST_WAIT_BUSY here covers the issuer's whole guard + busy-wait span.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:      if (start) w_state_nxt = ST_ISSUE;
            ST_ISSUE:     w_state_nxt = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (w_cmd_timeout) begin
                    w_state_nxt = ST_FINISH;
                end else if (w_cmd_done) begin
                    if (r_step == STEP_GET_ID || r_step == STEP_STATUS) begin
                        w_state_nxt = ST_CAPTURE;
                    end else if (r_step == STEP_PAGE) begin
                        w_state_nxt = ST_STREAM;
                    end else begin
                        w_state_nxt = ST_ISSUE;
                    end
                end
            end
            ST_CAPTURE:   w_state_nxt = ST_ISSUE;
            ST_STREAM:    if (pg_ready) w_state_nxt = w_pg_last ? ST_FINISH : ST_ISSUE;
            ST_FINISH:    w_state_nxt = ST_IDLE;
            default:      w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_step     <= STEP_RESET;
            r_pg_idx   <= '0;
            r_id_idx   <= '0;
            r_ce       <= '0;
            r_id_bytes <= '0;
            r_status   <= '0;
            r_pg_data  <= '0;
            r_error    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_error    <= 1'b0;
                        r_id_bytes <= '0;
                        r_ce       <= ce_sel;
                        r_step     <= STEP_RESET;
                        r_id_idx   <= '0;
                        r_pg_idx   <= '0;
                    end
                end
                ST_WAIT_BUSY: begin
                    if (w_cmd_timeout) begin
                        r_error <= 1'b1;
                    end else if (w_cmd_done) begin
                        if (r_step == STEP_PAGE) begin
                            r_pg_data <= nm_data_out;
                        end else if (r_step != STEP_GET_ID && r_step != STEP_STATUS) begin
                            r_step   <= seq_step_t'(r_step + 4'd1);
                            r_id_idx <= '0;
                            r_pg_idx <= '0;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (r_step == STEP_GET_ID) begin
                        r_id_bytes[{r_id_idx, 3'b000} +: 8] <= nm_data_out;
                        if (w_id_last) begin
                            r_step   <= STEP_STATUS;
                            r_id_idx <= '0;
                        end else begin
                            r_id_idx <= r_id_idx + 3'd1;
                        end
                    end else begin
                        r_status <= nm_data_out;
                        r_step   <= STEP_RST_IDX0;
                    end
                end
                ST_STREAM: begin
                    if (pg_ready && !w_pg_last) r_pg_idx <= r_pg_idx + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign id_bytes = r_id_bytes;
    assign status   = r_status;
    assign pg_data  = r_pg_data;
    assign pg_valid = (r_state == ST_STREAM);
    assign pg_last  = pg_valid && w_pg_last;
    assign seq_busy = (r_state != ST_IDLE);
    assign done     = (r_state == ST_FINISH);
    assign error    = r_error;

endmodule
`default_nettype wire

// File: tb/tb_nand_read_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// Bench for nand_read_sequencer: a behavioural nand_master model with random
// busy latency and a random-ready page sink, checked against rule-derived expectations.
module tb_nand_read_sequencer;

    localparam int PB = 4;
    localparam int IB = 5;
    localparam int GC = 2;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  ce_sel = 8'h00;
    logic [5:0]  nm_cmd;
    logic        nm_activate;
    logic [7:0]  nm_data_in;
    logic        nm_busy = 1'b0;
    logic [7:0]  nm_data_out = 8'h00;
    logic [63:0] id_bytes;
    logic [7:0]  status;
    logic [7:0]  pg_data;
    logic        pg_valid;
    logic        pg_ready = 1'b0;
    logic        pg_last;
    logic        seq_busy;
    logic        done;
    logic        error;

    int vectors = 0;
    int fails   = 0;

    logic [7:0]  id_rom [8];
    logic [7:0]  status_val = 8'h00;
    logic [7:0]  page [PB];
    int          id_ptr = 0;
    int          pg_ptr = 0;
    int          busy_rem = 0;
    int          bp_cnt = 0;
    bit          hang = 1'b0;
    bit          hang_active = 1'b0;
    bit          bp_mode = 1'b0;
    logic [13:0] trace [$];
    logic [13:0] exp_trace [$];
    logic [7:0]  got [$];
    bit          got_last [$];
    int          done_cnt = 0;
    int          hold_err = 0;
    int          act_pend_err = 0;
    int          act_wide_err = 0;
    bit          prev_act = 1'b0;
    bit          prev_valid = 1'b0;
    bit          prev_hs = 1'b0;
    logic [7:0]  prev_data = 8'h00;

    nand_read_sequencer #(
        .PAGE_BYTES     (PB),
        .ID_BYTES       (IB),
        .GUARD_CYCLES   (GC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .nreset      (nreset),
        .start       (start),
        .ce_sel      (ce_sel),
        .nm_cmd      (nm_cmd),
        .nm_activate (nm_activate),
        .nm_data_in  (nm_data_in),
        .nm_busy     (nm_busy),
        .nm_data_out (nm_data_out),
        .id_bytes    (id_bytes),
        .status      (status),
        .pg_data     (pg_data),
        .pg_valid    (pg_valid),
        .pg_ready    (pg_ready),
        .pg_last     (pg_last),
        .seq_busy    (seq_busy),
        .done        (done),
        .error       (error)
    );

    always #5 clk = ~clk;

    // nand_master model, page sink and monitors all live in one negedge
    // process so ready decisions and handshake observation never race.
    initial begin : nand_model
        int lat;
        forever begin
            @(negedge clk);
            if (!nreset) begin
                nm_busy     = 1'b0;
                busy_rem    = 0;
                hang_active = 1'b0;
                prev_act    = 1'b0;
                prev_valid  = 1'b0;
                pg_ready    = 1'b0;
            end else begin
                if (bp_mode && pg_valid && got.size() == 2 && bp_cnt < 10) begin
                    pg_ready = 1'b0;
                    bp_cnt++;
                end else begin
                    pg_ready = ($urandom_range(3) != 0);
                end
                if (prev_valid && !prev_hs && pg_valid && pg_data !== prev_data) hold_err++;
                prev_valid = pg_valid;
                prev_data  = pg_data;
                prev_hs    = pg_valid && pg_ready;
                if (pg_valid && pg_ready) begin
                    got.push_back(pg_data);
                    got_last.push_back(pg_last);
                end
                if (done) done_cnt++;
                if (hang_active && !hang) begin
                    hang_active = 1'b0;
                    nm_busy     = 1'b0;
                end
                if (busy_rem > 0) begin
                    busy_rem--;
                    if (busy_rem == 0 && !hang_active) nm_busy = 1'b0;
                end
                if (nm_activate) begin
                    if (prev_act) act_wide_err++;
                    if (pg_valid) act_pend_err++;
                    trace.push_back({nm_cmd, nm_data_in});
                    case (nm_cmd)
                        6'h06: id_ptr = 0;
                        6'h13: begin nm_data_out = id_rom[id_ptr[2:0]]; id_ptr++; end
                        6'h0D: nm_data_out = status_val;
                        6'h12: pg_ptr = 0;
                        6'h15: begin nm_data_out = (pg_ptr < PB) ? page[pg_ptr] : 8'hEE; pg_ptr++; end
                        default: nm_data_out = 8'($urandom);
                    endcase
                    lat = int'($urandom_range(8));
                    if (hang && nm_cmd == 6'h04) begin
                        hang_active = 1'b1;
                        nm_busy     = 1'b1;
                    end else if (lat > 0) begin
                        nm_busy  = 1'b1;
                        busy_rem = lat;
                    end
                end
                prev_act = nm_activate;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: time limit reached, observed no summary, expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic new_model(input bit fixed);
        if (fixed) begin
            id_rom     = '{8'h2C, 8'hE5, 8'hFF, 8'h03, 8'h86, 8'h11, 8'h22, 8'h33};
            status_val = 8'hE0;
        end else begin
            for (int k = 0; k < 8; k++) id_rom[k] = 8'($urandom);
            status_val = 8'($urandom);
        end
        for (int i = 0; i < PB; i++) page[i] = 8'($urandom);
    endtask

    task automatic clear_run;
        trace.delete();
        got.delete();
        got_last.delete();
        done_cnt     = 0;
        hold_err     = 0;
        act_pend_err = 0;
        act_wide_err = 0;
        bp_cnt       = 0;
    endtask

    // Expected command trace straight from the ROM order.
    task automatic build_exp(input logic [7:0] ce, input bit to_mode);
        exp_trace.delete();
        exp_trace.push_back({6'h01, 8'h00});
        exp_trace.push_back({6'h0E, ce});
        exp_trace.push_back({6'h04, 8'h00});
        if (!to_mode) begin
            exp_trace.push_back({6'h06, 8'h00});
            for (int k = 0; k < IB; k++) exp_trace.push_back({6'h13, 8'h00});
            exp_trace.push_back({6'h0D, 8'h00});
            exp_trace.push_back({6'h12, 8'h00});
            exp_trace.push_back({6'h09, 8'h00});
            exp_trace.push_back({6'h12, 8'h00});
            for (int i = 0; i < PB; i++) exp_trace.push_back({6'h15, 8'h00});
        end
    endtask

    task automatic pulse_start(input logic [7:0] ce);
        @(negedge clk);
        ce_sel = ce;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        ce_sel = 8'($urandom);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_in_budget"}, 64'(done_cnt != 0), 64'd1);
        repeat (6) @(negedge clk);
    endtask

    task automatic check_run(input string tag, input logic [7:0] ce, input bit to_mode);
        logic [63:0] exp_id;
        exp_id = '0;
        build_exp(ce, to_mode);
        if (!to_mode) for (int k = 0; k < IB; k++) exp_id = exp_id | (64'(id_rom[k]) << (8 * k));
        chk({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
        chk({tag, "_error"}, 64'(error), 64'(to_mode));
        chk({tag, "_seq_busy_idle"}, 64'(seq_busy), 64'd0);
        chk({tag, "_activate_count"}, 64'(trace.size()), 64'(exp_trace.size()));
        for (int i = 0; i < exp_trace.size() && i < trace.size(); i++)
            chk($sformatf("%s_cmd%0d", tag, i), 64'(trace[i]), 64'(exp_trace[i]));
        chk({tag, "_id_bytes"}, id_bytes, exp_id);
        if (!to_mode) begin
            chk({tag, "_status"}, 64'(status), 64'(status_val));
            chk({tag, "_page_beats"}, 64'(got.size()), 64'(PB));
            for (int i = 0; i < PB && i < got.size(); i++) begin
                chk($sformatf("%s_byte%0d", tag, i), 64'(got[i]), 64'(page[i]));
                chk($sformatf("%s_last%0d", tag, i), 64'(got_last[i]), 64'(i == PB - 1));
            end
        end
        chk({tag, "_pg_data_hold"}, 64'(hold_err), 64'd0);
        chk({tag, "_activate_while_pending"}, 64'(act_pend_err), 64'd0);
        chk({tag, "_activate_width"}, 64'(act_wide_err), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_nm_cmd"}, 64'(nm_cmd), 64'd0);
        chk({tag, "_nm_activate"}, 64'(nm_activate), 64'd0);
        chk({tag, "_nm_data_in"}, 64'(nm_data_in), 64'd0);
        chk({tag, "_id_bytes"}, id_bytes, 64'd0);
        chk({tag, "_status"}, 64'(status), 64'd0);
        chk({tag, "_pg_data"}, 64'(pg_data), 64'd0);
        chk({tag, "_pg_valid_last"}, 64'({pg_valid, pg_last}), 64'd0);
        chk({tag, "_seq_busy"}, 64'(seq_busy), 64'd0);
        chk({tag, "_done_error"}, 64'({done, error}), 64'd0);
    endtask

    initial begin : main
        logic [7:0] ce;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        nreset = 1'b1;
        repeat (2) @(negedge clk);

        // Nominal fixed ID/status, backpressure on byte 2, stray start mid-run
        clear_run();
        new_model(1'b1);
        bp_mode = 1'b1;
        pulse_start(8'h03);
        repeat (25) @(negedge clk);
        chk("nominal_busy_midrun", 64'(seq_busy), 64'd1);
        pulse_start(8'hA5);
        wait_done("nominal", 2000);
        check_run("nominal", 8'h03, 1'b0);
        chk("nominal_id_const", id_bytes, 64'h0000008603FFE52C);
        chk("nominal_bp_applied", 64'(bp_cnt), 64'd10);
        bp_mode = 1'b0;

        // Random ID, status, chip-enable and page contents
        clear_run();
        new_model(1'b0);
        ce = 8'($urandom);
        pulse_start(ce);
        wait_done("random", 2000);
        check_run("random", ce, 1'b0);

        // Busy stuck high after the NAND reset command
        clear_run();
        hang = 1'b1;
        ce = 8'($urandom);
        pulse_start(ce);
        wait_done("timeout", 200);
        check_run("timeout", ce, 1'b1);
        hang = 1'b0;
        repeat (3) @(negedge clk);

        // Restart after timeout clears error and runs cleanly
        clear_run();
        new_model(1'b0);
        ce = 8'($urandom);
        pulse_start(ce);
        chk("restart_error_cleared", 64'(error), 64'd0);
        wait_done("restart", 2000);
        check_run("restart", ce, 1'b0);

        // Asynchronous reset while streaming page bytes
        clear_run();
        new_model(1'b0);
        pulse_start(8'($urandom));
        for (int n = 0; n < 1000 && !pg_valid; n++) @(negedge clk);
        chk("midreset_stream_reached", 64'(pg_valid), 64'd1);
        @(posedge clk);
        #2 nreset = 1'b0;
        #1 check_all_zero("midreset");
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        repeat (2) @(negedge clk);

        clear_run();
        new_model(1'b0);
        ce = 8'($urandom);
        pulse_start(ce);
        wait_done("after_reset", 2000);
        check_run("after_reset", ce, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nand_read_sequencer.md
Name: nand_read_sequencer

Overview:
Sequences the nand_master command interface (cmd_in/activate/data_in/busy/data_out) through a complete bring-up and page-read flow without host involvement. One start pulse triggers a fixed command sequence: controller reset, chip enable, NAND reset, read ID, collect ID bytes, get status, reset buffer index, read page, reset index, then stream page bytes. The block sits between a host or system bus and nand_master. It captures the ID and status, and streams page data over a valid/ready interface with a busy-wait watchdog.

Parameters:
PAGE_BYTES, 528, number of MI_GET_DATA_PAGE_BYTE reads streamed per page (1..65535)
ID_BYTES, 5, number of MI_GET_ID_BYTE reads captured (1..8)
GUARD_CYCLES, 2, cycles waited after activate before busy is sampled (>=1)
TIMEOUT_CYCLES, 65536, maximum cycles busy may stay high per command before error

Ports:
clk  in  1  system clock
nreset  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins the sequence; ignored unless in IDLE
ce_sel  in  8  chip-enable selector passed as data_in with MI_CHIP_ENABLE; sampled at start
nm_cmd  out  6  to nand_master cmd_in
nm_activate  out  1  to nand_master activate
nm_data_in  out  8  to nand_master data_in
nm_busy  in  1  from nand_master busy
nm_data_out  in  8  from nand_master data_out
id_bytes  out  64  captured ID; byte k in bits [8k+7:8k]; unused bytes are 0
status  out  8  captured MI_GET_STATUS result
pg_data  out  8  page byte
pg_valid  out  1  pg_data valid
pg_ready  in  1  downstream accept
pg_last  out  1  high with the final page byte
seq_busy  out  1  high whenever not in IDLE
done  out  1  one-cycle pulse at sequence end (success or error)
error  out  1  sticky timeout flag; cleared at next accepted start

Behaviour:
- Reset values: all outputs 0. nm_cmd=0, id_bytes=0, status=0. State IDLE, step=0.
- Command ROM order (step: code, data_in): 0 M_RESET 0x01; 1 MI_CHIP_ENABLE 0x0E with ce_sel; 2 M_NAND_RESET 0x04; 3 M_NAND_READ_ID 0x06 with 0x00; 4 MI_GET_ID_BYTE 0x13 repeated ID_BYTES times; 5 MI_GET_STATUS 0x0D; 6 MI_RESET_INDEX 0x12; 7 M_NAND_READ 0x09; 8 MI_RESET_INDEX 0x12; 9 MI_GET_DATA_PAGE_BYTE 0x15 repeated PAGE_BYTES times. nm_data_in is 0 where not specified.
- FSM states: IDLE, ISSUE, GUARD, WAIT_BUSY, CAPTURE, STREAM, FINISH.
- IDLE: on start, clear error and id_bytes, latch ce_sel, step=0, then go to ISSUE.
- ISSUE: nm_cmd/nm_data_in driven from the ROM; nm_activate=1 for exactly this one cycle. nm_cmd stays stable from ISSUE until the next ISSUE. Then go to GUARD.
- GUARD: wait GUARD_CYCLES cycles, then go to WAIT_BUSY.
- WAIT_BUSY: wait for nm_busy==0, with the timeout counter running. On timeout, set error and go to FINISH.
- After busy is low: step 4 goes to CAPTURE (id_bytes[idx]=nm_data_out). Step 5 goes to CAPTURE (status=nm_data_out). Step 9 goes to STREAM. All other steps advance step and go to ISSUE.
- STREAM: pg_data=nm_data_out, pg_valid=1. pg_data is held stable until pg_ready. The handshake completes on the cycle both pg_valid and pg_ready are 1. pg_last=1 when byte count == PAGE_BYTES-1.
- After a completed handshake: if it was the last byte, go to FINISH; otherwise re-issue step 9. No new activate is issued while a byte is pending.
- Repeat counters: 16-bit index for page bytes, 3-bit index for ID bytes. Both clear on step entry.
- FINISH: done=1 for one cycle, then go to IDLE.
- A start received outside IDLE is ignored.
- If nm_busy is already high at ISSUE, there is no special case: GUARD/WAIT_BUSY cover it.
- Reset asserted mid-operation: immediate return to reset values. No partial done is generated.
- pg_ready held low forever: the block stalls in STREAM indefinitely. The timeout does not apply in STREAM.

Decomposition:
- Package nand_seq_pkg holds:
  - the command code constants (0x01, 0x0E, 0x04, 0x06, 0x13, 0x0D, 0x12, 0x09, 0x15), aligned with the nand_master defines;
  - the state enum;
  - the step enum.
- Sub-module nand_cmd_issuer implements ISSUE/GUARD/WAIT_BUSY plus the timeout for a single command. It returns a cmd_done/cmd_timeout pulse to the top-level step FSM.

Test Plan:
- Nominal, PAGE_BYTES=4, ID_BYTES=5, model returns ID 2C E5 FF 03 86 and status 0xE0 -> id_bytes=0x00000086_03FFE52C, status=0xE0, 4 pg_valid beats with pg_last on the 4th, one done pulse, error=0.
- Command trace check -> exactly 1+1+1+1+5+1+1+1+1+4 = 17 nm_activate pulses, each one cycle wide, in ROM order; MI_CHIP_ENABLE carries ce_sel=0x03.
- Backpressure: pg_ready low for 10 cycles on byte 2 -> pg_data stable, no extra nm_activate, all bytes delivered in order.
- Timeout: TIMEOUT_CYCLES=16, model holds busy high after M_NAND_RESET -> error=1 and done after ~16 cycles, step 3 never issued, back in IDLE; next start clears error.
- Async reset asserted during STREAM -> all outputs 0 immediately, seq_busy=0; a new start reruns the full sequence correctly.
- start pulsed while seq_busy=1 -> ignored; activate count unchanged from the nominal run.
